// File: rtl/joy_db15_pkg.sv
// joy_db15_pkg: shared types and frame constants for the DB15 joystick transmitter
package joy_db15_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
  localparam int FRAME_BITS = 32;
  localparam int PLAYER_BITS = 16;
endpackage

// File: rtl/joy_db15_tx_strobe_sync.sv
// strobe_sync: synchronizes an async strobe, filters it for stability and flags level edges
module strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = FILTER > 1 ? $clog2(FILTER) : 1;
  logic [SYNC_STAGES-1:0] sync_q;
  logic level_q, level_d, prev_q, s;
  logic [CW-1:0] cnt_q, cnt_d;
  // cnt_q counts consecutive samples that disagree with the accepted level
  always_comb begin
    s = sync_q[SYNC_STAGES-1];
    level_d = (s != level_q && cnt_q == CW'(FILTER - 1)) ? s : level_q;
    cnt_d = (s == level_q || level_d != level_q) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      prev_q <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      level_q <= level_d;
      prev_q <= level_q;
      cnt_q <= cnt_d;
    end
  end
  assign level_o = level_q;
  assign rise_o = level_q & ~prev_q;
  assign fall_o = ~level_q & prev_q;
endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: device-side DB15 joystick adapter emulator, 32-bit PISO answering LOAD/CLK strobes
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  input  logic JOY_LOAD,
  input  logic JOY_CLK,
  output logic JOY_DATA,
  output logic frame_done,
  output logic [5:0] bit_cnt
);
  state_e state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [5:0] cnt_q, cnt_d;
  logic done_q, done_d, data_q;
  logic ld_lvl, ld_rise, ld_fall, ck_lvl, ck_rise, ck_fall;
  strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER), .RESET_VAL(1'b1)) u_load (
    .clk_i(clk), .rst_i(reset), .pin_i(JOY_LOAD),
    .level_o(ld_lvl), .rise_o(ld_rise), .fall_o(ld_fall)
  );
  strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER), .RESET_VAL(1'b1)) u_clk (
    .clk_i(clk), .rst_i(reset), .pin_i(JOY_CLK),
    .level_o(ck_lvl), .rise_o(ck_rise), .fall_o(ck_fall)
  );
  logic unused_ok;
  assign unused_ok = &{1'b0, ld_fall, ck_lvl, ck_fall};
  // Load level dominates everything; a shift only happens with LOAD high and outside LOAD state
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (!ld_lvl) begin
      state_d = LOAD;
      sr_d = ~{joystick1, joystick2};
      cnt_d = '0;
    end else if (state_q == LOAD) begin
      state_d = ld_rise ? SHIFT : LOAD;
    end else if (ck_rise && (state_q == SHIFT || state_q == DONE)) begin
      sr_d = {sr_q[FRAME_BITS-2:0], 1'b1};
      cnt_d = (state_q == SHIFT) ? cnt_q + 6'd1 : cnt_q;
      done_d = state_q == SHIFT && cnt_q == 6'(FRAME_BITS - 1);
      state_d = done_d ? DONE : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q <= '1;
      cnt_q <= '0;
      done_q <= 1'b0;
      data_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      data_q <= sr_q[FRAME_BITS-1];
    end
  end
  assign JOY_DATA = data_q;
  assign frame_done = done_q;
  assign bit_cnt = cnt_q;
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: table vectors, corner sequences and randomized frames against a frame-level model
module tb_joy_db15_tx;
  localparam int H = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] joystick1 = '0, joystick2 = '0;
  logic JOY_LOAD = 1'b1, JOY_CLK = 1'b0;
  logic JOY_DATA, frame_done;
  logic [5:0] bit_cnt;
  int checks = 0, failures = 0, ndone = 0;
  logic [5:0] last_done_cnt = '0;
  joy_db15_tx dut (
    .clk(clk), .reset(reset), .joystick1(joystick1), .joystick2(joystick2),
    .JOY_LOAD(JOY_LOAD), .JOY_CLK(JOY_CLK), .JOY_DATA(JOY_DATA),
    .frame_done(frame_done), .bit_cnt(bit_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done) begin
    ndone <= ndone + 1;
    last_done_cnt <= bit_cnt;
  end
  typedef struct {
    logic [15:0] j1, j2;
    int k;
    logic data;
    logic [5:0] cnt;
    int frames;
  } vec_t;
  vec_t vecs[10];
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic load_seq(input logic [15:0] j1, input logic [15:0] j2);
    joystick1 = j1;
    joystick2 = j2;
    JOY_LOAD = 1'b0;
    wait_cyc(H);
    JOY_LOAD = 1'b1;
    wait_cyc(H);
  endtask
  task automatic pulse_clk();
    JOY_CLK = 1'b1;
    wait_cyc(H);
    JOY_CLK = 1'b0;
    wait_cyc(H);
  endtask
  function automatic logic exp_bit(input logic [15:0] j1, input logic [15:0] j2, input int k);
    if (k < 16) return ~j1[15-k];
    if (k < 32) return ~j2[31-k];
    return 1'b1;
  endfunction
  initial begin
    int base, n;
    logic [15:0] c1, c2;
    vecs[0] = '{16'h8000, 16'h0000, 0, 1'b0, 6'd0, 0};
    vecs[1] = '{16'h8000, 16'h0000, 1, 1'b1, 6'd1, 0};
    vecs[2] = '{16'h0A5F, 16'h3001, 4, 1'b0, 6'd4, 0};
    vecs[3] = '{16'h0A5F, 16'h3001, 16, 1'b1, 6'd16, 0};
    vecs[4] = '{16'h0A5F, 16'h3001, 18, 1'b0, 6'd18, 0};
    vecs[5] = '{16'h0A5F, 16'h3001, 31, 1'b0, 6'd31, 0};
    vecs[6] = '{16'h0A5F, 16'h3001, 32, 1'b1, 6'd32, 1};
    vecs[7] = '{16'h0A5F, 16'h3001, 40, 1'b1, 6'd32, 1};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 0, 1'b0, 6'd0, 0};
    vecs[9] = '{16'h0000, 16'h0000, 20, 1'b1, 6'd20, 0};
    wait_cyc(3);
    check("reset_data", 32'(JOY_DATA), 32'd1);
    check("reset_cnt", 32'(bit_cnt), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    wait_cyc(H);
    pulse_clk();
    check("idle_noshift_cnt", 32'(bit_cnt), 32'd0);
    check("idle_data", 32'(JOY_DATA), 32'd1);
    for (int i = 0; i < 10; i++) begin
      base = ndone;
      load_seq(vecs[i].j1, vecs[i].j2);
      for (int k = 0; k < vecs[i].k; k++) pulse_clk();
      check($sformatf("vec%0d_data", i), 32'(JOY_DATA), 32'(vecs[i].data));
      check($sformatf("vec%0d_cnt", i), 32'(bit_cnt), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_frames", i), 32'(ndone - base), 32'(vecs[i].frames));
      if (vecs[i].frames != 0) check($sformatf("vec%0d_done_cnt", i), 32'(last_done_cnt), 32'd32);
    end
    load_seq(16'h0A5F, 16'h3001);
    for (int k = 0; k < 3; k++) pulse_clk();
    JOY_CLK = 1'b1;
    wait_cyc(1);
    JOY_CLK = 1'b0;
    wait_cyc(H);
    check("glitch_cnt", 32'(bit_cnt), 32'd3);
    check("glitch_data", 32'(JOY_DATA), 32'(exp_bit(16'h0A5F, 16'h3001, 3)));
    JOY_LOAD = 1'b0;
    wait_cyc(H);
    JOY_LOAD = 1'b1;
    JOY_CLK = 1'b1;
    wait_cyc(H);
    check("prio_cnt", 32'(bit_cnt), 32'd0);
    check("prio_data", 32'(JOY_DATA), 32'(exp_bit(16'h0A5F, 16'h3001, 0)));
    JOY_CLK = 1'b0;
    wait_cyc(H);
    pulse_clk();
    check("prio_next_cnt", 32'(bit_cnt), 32'd1);
    base = ndone;
    load_seq(16'h1234, 16'h5678);
    for (int k = 0; k < 10; k++) pulse_clk();
    JOY_LOAD = 1'b0;
    joystick1 = 16'h7FFF;
    joystick2 = 16'h0000;
    wait_cyc(H);
    check("abort_cnt", 32'(bit_cnt), 32'd0);
    JOY_LOAD = 1'b1;
    wait_cyc(H);
    check("abort_bit0", 32'(JOY_DATA), 32'(exp_bit(16'h7FFF, 16'h0000, 0)));
    pulse_clk();
    check("abort_bit1", 32'(JOY_DATA), 32'(exp_bit(16'h7FFF, 16'h0000, 1)));
    check("abort_frames", 32'(ndone - base), 32'd0);
    load_seq(16'hC3C3, 16'h0F0F);
    for (int k = 0; k < 17; k++) pulse_clk();
    JOY_CLK = 1'b1;
    reset = 1'b1;
    wait_cyc(1);
    check("rst_mid_data", 32'(JOY_DATA), 32'd1);
    check("rst_mid_cnt", 32'(bit_cnt), 32'd0);
    reset = 1'b0;
    JOY_CLK = 1'b0;
    wait_cyc(H);
    for (int k = 0; k < 4; k++) pulse_clk();
    check("rst_noshift_cnt", 32'(bit_cnt), 32'd0);
    check("rst_noshift_data", 32'(JOY_DATA), 32'd1);
    for (int it = 0; it < 20; it++) begin
      c1 = 16'($urandom);
      c2 = 16'($urandom);
      n = $urandom_range(0, 40);
      base = ndone;
      load_seq(c1, c2);
      check($sformatf("rnd%0d_k0", it), 32'(JOY_DATA), 32'(exp_bit(c1, c2, 0)));
      for (int k = 1; k <= n; k++) begin
        if (k == n / 2) begin
          joystick1 = 16'($urandom);
          joystick2 = 16'($urandom);
        end
        pulse_clk();
        check($sformatf("rnd%0d_k%0d_data", it, k), 32'(JOY_DATA), 32'(exp_bit(c1, c2, k)));
        check($sformatf("rnd%0d_k%0d_cnt", it, k), 32'(bit_cnt), 32'(k < 32 ? k : 32));
      end
      check($sformatf("rnd%0d_frames", it), 32'(ndone - base), 32'(n >= 32 ? 1 : 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Device-side emulator of the DB15 serial joystick adapter: two cascaded parallel-in/serial-out shift registers, 16 bits per player. It answers the JOY_LOAD / JOY_CLK strobes that the joy_db15 reader drives on the UserIO port, and shifts out the current button states on JOY_DATA. It is used for loopback self-test of the UserIO joystick path and for bridging USB or on-screen inputs to an external DB15 host. It sits in the emu top level, beside joy_db15, on the CLK_JOY domain.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages on each asynchronous strobe input (minimum 2).
- FILTER, 2: consecutive identical synchronized samples required before a strobe level change is accepted (1 = no filtering).

Ports:
- clk  in  1  system clock, 40–50 MHz (CLK_JOY).
- reset  in  1  synchronous, active-high.
- joystick1  in  16  player 1 buttons, active-high, in the joy_db15 bit map (FEDCBAUDLR…).
- joystick2  in  16  player 2 buttons, same map.
- JOY_LOAD  in  1  asynchronous host strobe. Low = parallel load, high = shift enable.
- JOY_CLK  in  1  asynchronous host shift clock. Shifts on the rising edge.
- JOY_DATA  out  1  serial data, active-low buttons; idles high.
- frame_done  out  1  one-cycle pulse when the 32nd bit has been shifted out.
- bit_cnt  out  6  bits shifted since the last load, saturating at 32.

## Operation
Input conditioning:
- JOY_LOAD and JOY_CLK each pass through SYNC_STAGES flip-flops, then a FILTER-deep stability filter.
- Both the synchronizers and the filtered levels reset to 1.

Frame format:
- 32-bit shift register sr.
- Load value: sr = ~{joystick1[15:0], joystick2[15:0]}.
- JOY_DATA = sr[31], registered.
- Each shift: sr <= {sr[30:0], 1'b1}. The serial input is tied high.
- Frame bit k (k=0 is valid immediately after load) is ~joystick1[15-k] for k<16, and ~joystick2[31-k] for 16≤k<32.

State machine (state type lives in a package):
- IDLE: after reset. sr = all ones, bit_cnt = 0.
  - Filtered LOAD low → LOAD.
- LOAD: sr reloads from the joystick inputs every cycle, so loading is transparent. bit_cnt = 0.
  - Filtered LOAD rising → SHIFT.
- SHIFT: each filtered CLK rising edge shifts sr by one and increments bit_cnt.
  - When bit_cnt reaches 32: assert frame_done for one cycle, then → DONE.
- DONE: further CLK edges keep shifting ones in. bit_cnt holds at 32.
  - Filtered LOAD low → LOAD.

Boundary rules:
- A CLK rising edge while filtered LOAD is low is ignored; load dominates.
- CLK and LOAD edges accepted in the same cycle: the LOAD edge wins and no shift occurs.
- LOAD low during SHIFT (frame aborted): go to LOAD, clear bit_cnt, no frame_done.
- Joystick input changes in SHIFT or DONE do not affect sr until the next load.
- Reset in any state:
  - Next cycle: IDLE, JOY_DATA=1, frame_done=0, bit_cnt=0, sr all ones.
  - Synchronizers preset high, so no spurious edge is detected on release.

## Timing
- Reset values: JOY_DATA=1, frame_done=0, bit_cnt=0, state IDLE.
- Strobe acceptance latency: a pin change is acted on SYNC_STAGES+FILTER cycles after it, plus 1 cycle for the state/sr update.
- JOY_DATA is valid 1 cycle after that update. With defaults, that is 6 cycles after a pin edge.
- Host requirement: each JOY_CLK high and low phase, and the JOY_LOAD low pulse, must last at least SYNC_STAGES+FILTER+2 clk cycles.
  - Shorter pulses may be filtered out. This is legal and must not corrupt state.
- frame_done asserts in the same cycle bit_cnt becomes 32.

## Structure
- Package joy_db15_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - localparam FRAME_BITS = 32;
  - localparam PLAYER_BITS = 16.
- One sub-module, strobe_sync, instantiated twice (LOAD and CLK). Parameters SYNC_STAGES, FILTER, RESET_VAL. It outputs the filtered level plus one-cycle rise and fall pulses.

## Test plan
- Loopback:
  - Stimulus: connect to joy_db15 with joystick1=16'h0A5F, joystick2=16'h3001.
  - Response: after two reader frames, JOYDB15_1=16'h0A5F and JOYDB15_2=16'h3001.
- Bit order:
  - Stimulus: load joystick1=16'h8000, joystick2=0, then 32 clean CLK pulses.
  - Response: JOY_DATA is 0 at k=0 and 1 at k=1..31. Exactly one frame_done, with bit_cnt=32.
- Overshift:
  - Stimulus: 40 CLK pulses after a load.
  - Response: JOY_DATA stays 1 for bits 32..39, bit_cnt holds at 32, no second frame_done.
- Aborted frame:
  - Stimulus: LOAD goes low after 10 shifts.
  - Response: bit_cnt=0, no frame_done, and the next frame starts at bit 0 with the new inputs.
- Glitch and priority:
  - Stimulus: a 1-cycle JOY_CLK glitch, then CLK and LOAD edges in the same cycle.
  - Response: no shift in either case; sr holds the loaded value.
- Reset mid-frame:
  - Stimulus: assert reset at bit 17 with JOY_LOAD high and JOY_CLK toggling.
  - Response: JOY_DATA=1 and bit_cnt=0 on the next cycle. No shift occurs until a new LOAD low/high sequence.
